// File: rtl/washing_machine_sequencer.sv
// washing_machine_sequencer
//   Wash-cycle controller. On start it latches a 2-bit program and steps through
//   soak / wash / rinse (repeatable) / spin phases. Each phase is timed by an
//   internal down-counter. An open lid pauses the active phase, cancel aborts
//   to IDLE, and power_on low freezes every register.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, mode[1:0]  start request and program select (sampled in IDLE)
//   cancel, lid       abort request, lid-open indication
//   power_on          0 holds all state
//   state[2:0]        FSM state code
//   phase_sel[1:0]    active (or paused) phase code
//   soak_en..spin_en  per-phase enables
//   time_left         countdown value in phase/PAUSE states, else 0
//   busy, done        not-IDLE flag, single-cycle completion flag
module washing_machine_sequencer #(
  parameter int TIMER_W    = 16,
  parameter int SOAK_T     = 100,
  parameter int WASH_T     = 200,
  parameter int RINSE_T    = 80,
  parameter int RINSE_REPS = 2,
  parameter int SPIN_T     = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cancel,
  input  logic               lid,
  input  logic [1:0]         mode,
  input  logic               power_on,
  output logic [2:0]         state,
  output logic [1:0]         phase_sel,
  output logic               soak_en,
  output logic               wash_en,
  output logic               rinse_en,
  output logic               spin_en,
  output logic [TIMER_W-1:0] time_left,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_SOAK  = 3'd2;
  localparam logic [2:0] S_WASH  = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_PAUSE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] PH_SOAK  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_RINSE = 2'd2;
  localparam logic [1:0] PH_SPIN  = 2'd3;

  localparam logic [TIMER_W-1:0] SOAK_L  = TIMER_W'(SOAK_T - 1);
  localparam logic [TIMER_W-1:0] WASH_L  = TIMER_W'(WASH_T - 1);
  localparam logic [TIMER_W-1:0] RINSE_L = TIMER_W'(RINSE_T - 1);
  localparam logic [TIMER_W-1:0] SPIN_L  = TIMER_W'(SPIN_T - 1);

  // Pass counter must hold values 0..RINSE_REPS.
  localparam int PW = (RINSE_REPS < 2) ? 1 : $clog2(RINSE_REPS + 1);

  logic [1:0]         mode_q, saved;
  logic [PW-1:0]      passes;
  logic [TIMER_W-1:0] cnt;

  logic [2:0]         nxt_state;
  logic [1:0]         nxt_mode, nxt_saved;
  logic [PW-1:0]      nxt_passes;
  logic [TIMER_W-1:0] nxt_cnt;
  logic               enter;
  logic [1:0]         enter_ph;
  logic [1:0]         cur_ph;
  logic [PW:0]        pass_inc, reps;
  logic               in_phase;

  // Phase states are encoded 2..5, so phase code = state - 2.
  assign cur_ph   = state[1:0] - 2'd2;
  assign in_phase = (state >= S_SOAK) && (state <= S_SPIN);
  assign pass_inc = {1'b0, passes} + (PW+1)'(1);
  assign reps     = (mode_q == 2'd1) ? (PW+1)'(1) : (PW+1)'(RINSE_REPS);

  always_comb begin
    nxt_state  = state;
    nxt_mode   = mode_q;
    nxt_saved  = saved;
    nxt_passes = passes;
    nxt_cnt    = cnt;
    enter      = 1'b0;
    enter_ph   = PH_SOAK;
    case (state)
      S_IDLE: begin
        if (start && !lid) begin
          nxt_state = S_READY;
          nxt_mode  = mode;
        end
      end
      S_READY: begin
        if (cancel) begin
          nxt_state = S_IDLE;
        end else if (!lid) begin
          // The program number happens to equal the code of its first phase.
          enter    = 1'b1;
          enter_ph = mode_q;
        end
      end
      S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else if (lid) begin
          nxt_state = S_PAUSE;
          nxt_saved = cur_ph;
        end else if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else begin
          case (state)
            S_SOAK: begin
              enter    = 1'b1;
              enter_ph = PH_WASH;
            end
            S_WASH: begin
              enter    = 1'b1;
              enter_ph = PH_RINSE;
            end
            S_RINSE: begin
              nxt_passes = pass_inc[PW-1:0];
              if (pass_inc < reps) begin
                nxt_cnt = RINSE_L;
              end else begin
                enter    = 1'b1;
                enter_ph = PH_SPIN;
              end
            end
            default: nxt_state = S_DONE;
          endcase
        end
      end
      S_PAUSE: begin
        if (cancel) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else if (!lid) begin
          // Resume with the held count; no reload.
          nxt_state = {1'b0, saved} + S_SOAK;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (enter) begin
      nxt_state = {1'b0, enter_ph} + S_SOAK;
      case (enter_ph)
        PH_SOAK:  nxt_cnt = SOAK_L;
        PH_WASH:  nxt_cnt = WASH_L;
        PH_RINSE: nxt_cnt = RINSE_L;
        default:  nxt_cnt = SPIN_L;
      endcase
      // Fresh rinse sequence; repeat passes reload in place above.
      if (enter_ph == PH_RINSE) nxt_passes = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= 2'd0;
      saved  <= 2'd0;
      passes <= '0;
      cnt    <= '0;
    end else if (power_on) begin
      state  <= nxt_state;
      mode_q <= nxt_mode;
      saved  <= nxt_saved;
      passes <= nxt_passes;
      cnt    <= nxt_cnt;
    end
  end

  always_comb begin
    phase_sel = 2'd0;
    if (in_phase)              phase_sel = cur_ph;
    else if (state == S_PAUSE) phase_sel = saved;
  end

  assign soak_en   = (state == S_SOAK);
  assign wash_en   = (state == S_WASH);
  assign rinse_en  = (state == S_RINSE);
  assign spin_en   = (state == S_SPIN);
  assign time_left = (in_phase || state == S_PAUSE) ? cnt : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_washing_machine_sequencer.sv
// Directed bench for washing_machine_sequencer with short phase durations.
// Each step pushes the expected post-edge output snapshot to a queue, advances
// one clock, then pops and compares it against the DUT outputs.
module tb_washing_machine_sequencer;

  logic        clk, rst, start, cancel, lid, power_on;
  logic [1:0]  mode;
  logic [2:0]  state;
  logic [1:0]  phase_sel;
  logic        soak_en, wash_en, rinse_en, spin_en, busy, done;
  logic [15:0] time_left;

  washing_machine_sequencer #(
    .TIMER_W(16), .SOAK_T(4), .WASH_T(6), .RINSE_T(3), .RINSE_REPS(2), .SPIN_T(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .lid(lid), .mode(mode),
    .power_on(power_on), .state(state), .phase_sel(phase_sel), .soak_en(soak_en),
    .wash_en(wash_en), .rinse_en(rinse_en), .spin_en(spin_en), .time_left(time_left),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  ps;
    logic [3:0]  en;   // {soak, wash, rinse, spin}
    logic [15:0] tl;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic [2:0] st, logic [1:0] ps, int tl);
    exp_t e;
    e.st   = st;
    e.ps   = ps;
    e.en   = {st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd5};
    e.tl   = 16'(tl);
    e.busy = (st != 3'd0);
    e.done = (st == 3'd7);
    return e;
  endfunction

  task automatic cyc(string tag, exp_t e);
    exp_t got, want;
    q.push_back(e);
    @(posedge clk);
    #1;
    got  = {state, phase_sel, soak_en, wash_en, rinse_en, spin_en, time_left, busy, done};
    want = q.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got st=%0d ps=%0d en=%b tl=%0d busy=%b done=%b, want st=%0d ps=%0d en=%b tl=%0d busy=%b done=%b",
             tag, got.st, got.ps, got.en, got.tl, got.busy, got.done,
             want.st, want.ps, want.en, want.tl, want.busy, want.done);
    end
  endtask

  // n cycles in state st; time_left starts at tl0 and drops by dec each cycle.
  task automatic run(string tag, int n, logic [2:0] st, logic [1:0] ps, int tl0, int dec);
    for (int i = 0; i < n; i++) cyc(tag, mk(st, ps, tl0 - i * dec));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; lid = 1'b0; mode = 2'd0; power_on = 1'b1;
    cyc("reset", mk(3'd0, 2'd0, 0));
    rst = 1'b0;
    cyc("idle", mk(3'd0, 2'd0, 0));

    // Full program
    start = 1'b1; mode = 2'd0;
    cyc("full_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    run("full_soak", 4, 3'd2, 2'd0, 3, 1);
    run("full_wash", 6, 3'd3, 2'd1, 5, 1);
    run("full_rinse1", 3, 3'd4, 2'd2, 2, 1);
    run("full_rinse2", 3, 3'd4, 2'd2, 2, 1);
    run("full_spin", 5, 3'd5, 2'd3, 4, 1);
    cyc("full_done", mk(3'd7, 2'd0, 0));
    start = 1'b1;
    cyc("done_ignores_start", mk(3'd0, 2'd0, 0));
    start = 1'b0;
    cyc("full_idle", mk(3'd0, 2'd0, 0));

    // Quick program; mode change after latch must not matter
    start = 1'b1; mode = 2'd1;
    cyc("quick_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0; mode = 2'd0;
    run("quick_wash", 6, 3'd3, 2'd1, 5, 1);
    run("quick_rinse", 3, 3'd4, 2'd2, 2, 1);
    run("quick_spin", 5, 3'd5, 2'd3, 4, 1);
    cyc("quick_done", mk(3'd7, 2'd0, 0));
    cyc("quick_idle", mk(3'd0, 2'd0, 0));

    // Lid pause in WASH, lid at counter zero in RINSE, power loss in SPIN
    start = 1'b1; mode = 2'd1;
    cyc("lid_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    run("lid_wash_a", 3, 3'd3, 2'd1, 5, 1);
    lid = 1'b1;
    run("lid_pause", 4, 3'd6, 2'd1, 3, 0);
    lid = 1'b0;
    run("lid_wash_b", 4, 3'd3, 2'd1, 3, 1);
    run("lid_rinse", 3, 3'd4, 2'd2, 2, 1);
    lid = 1'b1;
    cyc("lid_zero_pause", mk(3'd6, 2'd2, 0));
    lid = 1'b0;
    cyc("lid_zero_resume", mk(3'd4, 2'd2, 0));
    run("pwr_spin_a", 2, 3'd5, 2'd3, 4, 1);
    power_on = 1'b0;
    run("pwr_frozen", 3, 3'd5, 2'd3, 3, 0);
    power_on = 1'b1;
    run("pwr_spin_b", 3, 3'd5, 2'd3, 2, 1);
    cyc("pwr_done", mk(3'd7, 2'd0, 0));
    cyc("pwr_idle", mk(3'd0, 2'd0, 0));

    // Cancel in second rinse pass (rinse+spin program)
    start = 1'b1; mode = 2'd2;
    cyc("rs_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    run("rs_rinse1", 3, 3'd4, 2'd2, 2, 1);
    cyc("rs_rinse2", mk(3'd4, 2'd2, 2));
    cancel = 1'b1;
    cyc("rs_cancel", mk(3'd0, 2'd0, 0));
    cancel = 1'b0;

    // Spin only; cancel beats lid while paused
    start = 1'b1; mode = 2'd3;
    cyc("sp_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    cyc("sp_spin", mk(3'd5, 2'd3, 4));
    lid = 1'b1;
    cyc("sp_pause", mk(3'd6, 2'd3, 4));
    cancel = 1'b1;
    cyc("sp_cancel_lid", mk(3'd0, 2'd0, 0));
    cancel = 1'b0; lid = 1'b0;

    // Start with lid open is dropped; reset mid-soak
    start = 1'b1; lid = 1'b1; mode = 2'd0;
    cyc("lid_start", mk(3'd0, 2'd0, 0));
    start = 1'b0; lid = 1'b0;
    cyc("lid_start_forgot", mk(3'd0, 2'd0, 0));
    start = 1'b1;
    cyc("rst_ready", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    run("rst_soak_a", 2, 3'd2, 2'd0, 3, 1);
    rst = 1'b1;
    cyc("rst_mid", mk(3'd0, 2'd0, 0));
    rst = 1'b0; start = 1'b1;
    cyc("rst_ready2", mk(3'd1, 2'd0, 0));
    start = 1'b0;
    run("rst_soak_b", 4, 3'd2, 2'd0, 3, 1);
    cyc("rst_wash", mk(3'd3, 2'd1, 5));
    cancel = 1'b1;
    cyc("rst_cancel", mk(3'd0, 2'd0, 0));
    cancel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
